// File: rtl/gelato_inst_buffer.sv
// Per-warp instruction buffer: one FIFO per warp fed by decode, drained by the issue scheduler.
// Full/ready status comes from registered counts; issue data appears one cycle after the request.
module gelato_inst_buffer #(
    parameter int unsigned NUM_WARPS  = 4,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned WARP_W     = $clog2(NUM_WARPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  in_valid,
    input  logic [PC_WIDTH-1:0]   in_pc,
    input  logic [WARP_W-1:0]     in_warp_num,
    input  logic [INST_WIDTH-1:0] in_inst,
    output logic [NUM_WARPS-1:0]  warp_full,
    output logic [NUM_WARPS-1:0]  warp_ready,
    input  logic                  issue_valid,
    input  logic [WARP_W-1:0]     issue_warp_num,
    input  logic [NUM_WARPS-1:0]  flush_mask,
    output logic                  out_valid,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [WARP_W-1:0]     out_warp_num,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic                  overflow_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]      wptr_q  [NUM_WARPS];
    logic [PTR_W-1:0]      wptr_d  [NUM_WARPS];
    logic [PTR_W-1:0]      rptr_q  [NUM_WARPS];
    logic [PTR_W-1:0]      rptr_d  [NUM_WARPS];
    logic [CNT_W-1:0]      count_q [NUM_WARPS];
    logic [CNT_W-1:0]      count_d [NUM_WARPS];

    logic [PC_WIDTH-1:0]   pc_mem   [NUM_WARPS][DEPTH];
    logic [INST_WIDTH-1:0] inst_mem [NUM_WARPS][DEPTH];

    logic push_en;
    logic pop_en;
    logic overflow_set;

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            warp_full[w]  = (count_q[w] == CNT_W'(DEPTH));
            warp_ready[w] = (count_q[w] != '0);
        end
    end

    // A flush of the target warp cancels both the push and the pop in the same cycle.
    assign push_en      = rdy && in_valid && !warp_full[in_warp_num] && !flush_mask[in_warp_num];
    assign pop_en       = rdy && issue_valid && warp_ready[issue_warp_num]
                          && !flush_mask[issue_warp_num];
    assign overflow_set = rdy && in_valid && warp_full[in_warp_num];

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            logic push_w;
            logic pop_w;
            push_w     = push_en && (in_warp_num == WARP_W'(w));
            pop_w      = pop_en && (issue_warp_num == WARP_W'(w));
            wptr_d[w]  = wptr_q[w];
            rptr_d[w]  = rptr_q[w];
            count_d[w] = count_q[w];
            if (rdy && flush_mask[w]) begin
                wptr_d[w]  = '0;
                rptr_d[w]  = '0;
                count_d[w] = '0;
            end else begin
                if (push_w) wptr_d[w] = wptr_q[w] + PTR_W'(1);
                if (pop_w)  rptr_d[w] = rptr_q[w] + PTR_W'(1);
                count_d[w] = count_q[w] + CNT_W'(push_w) - CNT_W'(pop_w);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                wptr_q[w]  <= '0;
                rptr_q[w]  <= '0;
                count_q[w] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                wptr_q[w]  <= wptr_d[w];
                rptr_q[w]  <= rptr_d[w];
                count_q[w] <= count_d[w];
            end
        end
    end

    // Storage needs no reset; entries are only read when the count says they are valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            pc_mem[in_warp_num][wptr_q[in_warp_num]]   <= in_pc;
            inst_mem[in_warp_num][wptr_q[in_warp_num]] <= in_inst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_warp_num <= '0;
            out_inst     <= '0;
            overflow_err <= 1'b0;
        end else begin
            out_valid <= pop_en;
            if (pop_en) begin
                out_pc       <= pc_mem[issue_warp_num][rptr_q[issue_warp_num]];
                out_warp_num <= issue_warp_num;
                out_inst     <= inst_mem[issue_warp_num][rptr_q[issue_warp_num]];
            end
            if (overflow_set) overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gelato_inst_buffer.sv
// Directed bench for gelato_inst_buffer: push/issue ordering, overflow, flush, freeze and reset.
module tb_gelato_inst_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [1:0]  in_warp_num;
    logic [31:0] in_inst;
    logic [3:0]  warp_full;
    logic [3:0]  warp_ready;
    logic        issue_valid;
    logic [1:0]  issue_warp_num;
    logic [3:0]  flush_mask;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [1:0]  out_warp_num;
    logic [31:0] out_inst;
    logic        overflow_err;

    int checks   = 0;
    int failures = 0;

    gelato_inst_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .in_valid       (in_valid),
        .in_pc          (in_pc),
        .in_warp_num    (in_warp_num),
        .in_inst        (in_inst),
        .warp_full      (warp_full),
        .warp_ready     (warp_ready),
        .issue_valid    (issue_valid),
        .issue_warp_num (issue_warp_num),
        .flush_mask     (flush_mask),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_warp_num   (out_warp_num),
        .out_inst       (out_inst),
        .overflow_err   (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid    = 1'b0;
        issue_valid = 1'b0;
        flush_mask  = 4'b0000;
        rdy         = 1'b1;
    endtask

    task automatic push(input logic [1:0] w, input logic [31:0] pc);
        in_valid    = 1'b1;
        in_warp_num = w;
        in_pc       = pc;
        in_inst     = pc ^ 32'hA5A5_0000;
        cyc();
        in_valid    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        in_pc = '0; in_warp_num = '0; in_inst = '0; issue_warp_num = '0;
        cyc();
        checks++;
        if ({warp_full, warp_ready, out_valid, overflow_err} !== 10'd0 || out_pc !== 32'd0
            || out_inst !== 32'd0 || out_warp_num !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: full=%b ready=%b ov=%b err=%b pc=%h inst=%h warp=%0d want 0",
                     warp_full, warp_ready, out_valid, overflow_err, out_pc, out_inst, out_warp_num);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_push_issue();
        push(2'd1, 32'h100);
        push(2'd1, 32'h104);
        checks++;
        if (warp_ready !== 4'b0010) begin
            failures++;
            $display("FAIL push_ready: got %b want 0010", warp_ready);
        end
        issue_valid = 1'b1; issue_warp_num = 2'd1;
        cyc();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_warp_num !== 2'd1
            || out_inst !== (32'h100 ^ 32'hA5A5_0000)) begin
            failures++;
            $display("FAIL issue_first: valid=%b pc=%h warp=%0d inst=%h want 1/100/1/a5a50100",
                     out_valid, out_pc, out_warp_num, out_inst);
        end
        cyc();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h104) begin
            failures++;
            $display("FAIL issue_second: valid=%b pc=%h want 1/104", out_valid, out_pc);
        end
        issue_valid = 1'b0;
        cyc();
        checks++;
        if (out_valid !== 1'b0 || warp_ready !== 4'b0000) begin
            failures++;
            $display("FAIL issue_drain: valid=%b ready=%b want 0/0000", out_valid, warp_ready);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) push(2'd2, 32'h200 + 32'(4 * i));
        checks++;
        if (warp_full !== 4'b0100 || overflow_err !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: full=%b err=%b want 0100/0", warp_full, overflow_err);
        end
        push(2'd2, 32'h210);
        checks++;
        if (overflow_err !== 1'b1 || warp_full !== 4'b0100) begin
            failures++;
            $display("FAIL overflow: err=%b full=%b want 1/0100", overflow_err, warp_full);
        end
        issue_valid = 1'b1; issue_warp_num = 2'd2;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h200 + 32'(4 * i)) begin
                failures++;
                $display("FAIL overflow_drain[%0d]: valid=%b pc=%h want 1/%h",
                         i, out_valid, out_pc, 32'h200 + 32'(4 * i));
            end
        end
        cyc();
        issue_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || warp_ready !== 4'b0000 || overflow_err !== 1'b1) begin
            failures++;
            $display("FAIL overflow_dropped: valid=%b ready=%b err=%b want 0/0000/1",
                     out_valid, warp_ready, overflow_err);
        end
    endtask

    task automatic test_push_pop_same();
        push(2'd0, 32'h300);
        push(2'd0, 32'h304);
        in_valid = 1'b1; in_warp_num = 2'd0; in_pc = 32'h308; in_inst = 32'h308;
        issue_valid = 1'b1; issue_warp_num = 2'd0;
        cyc();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h300 || warp_ready !== 4'b0001
            || warp_full !== 4'b0000) begin
            failures++;
            $display("FAIL push_pop_same: valid=%b pc=%h ready=%b full=%b want 1/300/0001/0000",
                     out_valid, out_pc, warp_ready, warp_full);
        end
        cyc();
        checks++;
        if (out_pc !== 32'h304) begin
            failures++;
            $display("FAIL push_pop_order1: pc=%h want 304", out_pc);
        end
        cyc();
        issue_valid = 1'b0;
        checks++;
        if (out_pc !== 32'h308 || out_valid !== 1'b1 || warp_ready !== 4'b0000) begin
            failures++;
            $display("FAIL push_pop_order2: pc=%h valid=%b ready=%b want 308/1/0000",
                     out_pc, out_valid, warp_ready);
        end
    endtask

    task automatic test_flush();
        push(2'd1, 32'h400);
        push(2'd3, 32'h500);
        push(2'd3, 32'h504);
        push(2'd3, 32'h508);
        flush_mask = 4'b1000;
        in_valid = 1'b1; in_warp_num = 2'd3; in_pc = 32'h50C;
        issue_valid = 1'b1; issue_warp_num = 2'd3;
        cyc();
        idle();
        checks++;
        if (out_valid !== 1'b0 || warp_ready !== 4'b0010) begin
            failures++;
            $display("FAIL flush: valid=%b ready=%b want 0/0010", out_valid, warp_ready);
        end
        issue_valid = 1'b1; issue_warp_num = 2'd1;
        cyc();
        issue_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h400) begin
            failures++;
            $display("FAIL flush_other_warp: valid=%b pc=%h want 1/400", out_valid, out_pc);
        end
    endtask

    task automatic test_empty_and_freeze();
        // Push and issue the same empty warp together: no bypass, so no issue.
        in_valid = 1'b1; in_warp_num = 2'd0; in_pc = 32'h600;
        issue_valid = 1'b1; issue_warp_num = 2'd0;
        cyc();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || warp_ready !== 4'b0001) begin
            failures++;
            $display("FAIL empty_issue: valid=%b ready=%b want 0/0001", out_valid, warp_ready);
        end
        rdy = 1'b0;
        in_valid = 1'b1; in_pc = 32'h604; flush_mask = 4'b0001;
        cyc();
        checks++;
        if (out_valid !== 1'b0 || warp_ready !== 4'b0001 || warp_full !== 4'b0000) begin
            failures++;
            $display("FAIL freeze: valid=%b ready=%b full=%b want 0/0001/0000",
                     out_valid, warp_ready, warp_full);
        end
        idle();
        issue_valid = 1'b1; issue_warp_num = 2'd0;
        cyc();
        issue_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h600 || warp_ready !== 4'b0000) begin
            failures++;
            $display("FAIL freeze_resume: valid=%b pc=%h ready=%b want 1/600/0000",
                     out_valid, out_pc, warp_ready);
        end
    endtask

    task automatic test_reset_mid();
        push(2'd1, 32'h700);
        push(2'd1, 32'h704);
        push(2'd2, 32'h800);
        issue_valid = 1'b1; issue_warp_num = 2'd1;
        cyc();
        issue_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || warp_ready !== 4'b0110) begin
            failures++;
            $display("FAIL pre_reset: valid=%b ready=%b want 1/0110", out_valid, warp_ready);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({warp_full, warp_ready, out_valid, overflow_err} !== 10'd0 || out_pc !== 32'd0
            || out_inst !== 32'd0 || out_warp_num !== 2'd0) begin
            failures++;
            $display("FAIL async_reset: full=%b ready=%b ov=%b err=%b pc=%h warp=%0d want 0",
                     warp_full, warp_ready, out_valid, overflow_err, out_pc, out_warp_num);
        end
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_push_issue();
        test_overflow();
        test_push_pop_same();
        test_flush();
        test_empty_and_freeze();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
